sort_seq_ctrl: RTL and testbench

- Sequential sorter built around one shared 4-bit magnitude comparator, comparator_4bit_struct, which is time-multiplexed across all compare steps.
- Accepts DEPTH 4-bit values over a valid/ready input stream and bubble-sorts them in an internal register array, one compare/swap per cycle.
- Streams the sorted result out over a valid/ready output stream.
- Reports the number of swaps performed, as a verification and debug hook.

---
 rtl/sort_seq_pkg.sv | 20 ++
 rtl/sort_seq_ctrl_cmp.sv | 20 ++
 rtl/sort_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sort_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_seq_pkg.sv
// Shared definitions for the sequential sorter.
//   state_t    : FSM state encoding (LOAD / SORT / DRAIN)
//   ELEM_W     : element width, fixed by the 4-bit comparator
//   idx_width(): width of an index that addresses DEPTH entries
package sort_seq_pkg;

  localparam int ELEM_W = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Never narrower than one bit, so DEPTH = 2 still gets a usable index.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sort_seq_ctrl_cmp.sv
// 4-bit unsigned magnitude comparator, shared by every compare step.
//   a, b           : operands
//   a_maior_que_b  : a > b
//   a_menor_que_b  : a < b
//   a_igual_b      : a == b
module comparator_4bit_struct
  import sort_seq_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic              a_maior_que_b,
  output logic              a_menor_que_b,
  output logic              a_igual_b
);

  assign a_maior_que_b = (a > b);
  assign a_menor_que_b = (a < b);
  assign a_igual_b     = (a == b);

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential bubble sorter: loads DEPTH elements over a valid/ready stream,
// sorts them in place with one compare/swap per cycle through a single
// shared comparator, then streams the result out.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_data element, desc order
//   out_valid/out_ready   : output handshake, out_data element, out_last
//   busy                  : sorting or draining
//   swap_count            : swaps done by the most recent sort (saturating)
module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              desc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        swap_count
);

  localparam int            IW        = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

  state_t            state_r, state_next_s;
  logic [ELEM_W-1:0] mem_r [DEPTH];
  logic [IW-1:0]     load_idx_r, j_r, pass_r, out_idx_r;
  logic              desc_r, pass_swapped_r;

  logic [IW-1:0]     j_next_s, out_idx_next_s, pass_end_j_s;
  logic [ELEM_W-1:0] cmp_a_s, cmp_b_s;
  logic              a_gt_s, a_lt_s, a_eq_s;
  logic              accept_in_s, do_swap_s, pass_end_s, sort_done_s;

  assign j_next_s       = j_r + IW'(1);
  assign out_idx_next_s = out_idx_r + IW'(1);
  // Each pass leaves its largest (or smallest) element parked at the end,
  // so the compare window shrinks by one per pass.
  assign pass_end_j_s   = LAST_PASS - pass_r;

  assign in_ready = (state_r == LOAD) && !rst;

  // Operand mux: the comparator always looks at the adjacent pair at j.
  assign cmp_a_s = mem_r[j_r];
  assign cmp_b_s = mem_r[j_next_s];

  comparator_4bit_struct u_cmp (
    .a             (cmp_a_s),
    .b             (cmp_b_s),
    .a_maior_que_b (a_gt_s),
    .a_menor_que_b (a_lt_s),
    .a_igual_b     (a_eq_s)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s = state_r;
    accept_in_s  = 1'b0;
    do_swap_s    = 1'b0;
    pass_end_s   = 1'b0;
    sort_done_s  = 1'b0;
    case (state_r)
      LOAD: begin
        accept_in_s = in_valid;
        if (in_valid && (load_idx_r == LAST_IDX)) begin
          state_next_s = SORT;
        end else begin
          state_next_s = LOAD;
        end
      end
      SORT: begin
        // Equal pairs never swap, which keeps the sort stable.
        do_swap_s  = !a_eq_s && (desc_r ? a_lt_s : a_gt_s);
        pass_end_s = (j_r == pass_end_j_s);
        // A pass with no swap (including this cycle's) proves the array sorted.
        if (pass_end_s && (!(pass_swapped_r || do_swap_s) || (pass_r == LAST_PASS))) begin
          sort_done_s  = 1'b1;
          state_next_s = DRAIN;
        end else begin
          state_next_s = SORT;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = LOAD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Element storage: written by loads and by swaps; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && accept_in_s) begin
      mem_r[load_idx_r] <= in_data;
    end else if (!rst && (state_r == SORT) && do_swap_s) begin
      mem_r[j_r]      <= cmp_b_s;
      mem_r[j_next_s] <= cmp_a_s;
    end
  end

  // Indices, sort bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx_r     <= '0;
      j_r            <= '0;
      pass_r         <= '0;
      pass_swapped_r <= 1'b0;
      out_idx_r      <= '0;
      desc_r         <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_data       <= '0;
      busy           <= 1'b0;
      swap_count     <= 8'd0;
    end else begin
      busy <= (state_next_s != LOAD);

      if (accept_in_s) begin
        load_idx_r <= (load_idx_r == LAST_IDX) ? '0 : (load_idx_r + IW'(1));
        // First beat of a batch fixes the order and starts a fresh swap tally.
        if (load_idx_r == '0) begin
          desc_r     <= desc;
          swap_count <= 8'd0;
        end
      end

      if (state_r == SORT) begin
        if (do_swap_s && (swap_count != 8'hFF)) begin
          swap_count <= swap_count + 8'd1;
        end
        if (pass_end_s) begin
          j_r            <= '0;
          pass_swapped_r <= 1'b0;
          pass_r         <= sort_done_s ? '0 : (pass_r + IW'(1));
        end else begin
          j_r            <= j_next_s;
          pass_swapped_r <= pass_swapped_r | do_swap_s;
        end
      end

      if (state_r == DRAIN) begin
        if (!out_valid) begin
          // First cycle in DRAIN presents element 0.
          out_valid <= 1'b1;
          out_data  <= mem_r[out_idx_r];
          out_last  <= (out_idx_r == LAST_IDX);
        end else if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx_r <= '0;
          end else begin
            out_idx_r <= out_idx_next_s;
            out_data  <= mem_r[out_idx_next_s];
            out_last  <= (out_idx_next_s == LAST_IDX);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl (DEPTH = 4). Expected results come
// from a reference model: library sort for the data, inversion counting for
// the swap count, and the longest displacement for the early-exit length.
module tb_sort_seq_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       desc;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic [7:0] swap_count;

  int n_checks = 0;
  int n_fail   = 0;

  sort_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .desc       (desc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int v[DEPTH], input bit d, output int s[DEPTH],
                       output int swaps, output int cycles);
    int q[$];
    int lmax;
    int c;
    int passes;
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(v[i]);
    if (d) q.rsort(); else q.sort();
    for (int i = 0; i < DEPTH; i++) s[i] = q[i];
    // Bubble sort swaps = strict inversions; passes that swap = longest
    // leftward travel of any element; one extra clean pass ends the sort.
    swaps = 0;
    lmax  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      c = 0;
      for (int j = 0; j < i; j++) begin
        if (d ? (v[j] < v[i]) : (v[j] > v[i])) c++;
      end
      swaps += c;
      if (c > lmax) lmax = c;
    end
    passes = (lmax + 1 < DEPTH - 1) ? lmax + 1 : DEPTH - 1;
    cycles = 0;
    for (int p = 0; p < passes; p++) cycles += DEPTH - 1 - p;
  endtask

  // Present DEPTH beats back to back; desc only matters on the first one.
  task automatic load_batch(input int v[DEPTH], input bit d);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(v[i]);
      desc     = (i == 0) ? d : ~d;
      check("in_ready_load", in_ready, 1);
      tick();
    end
  endtask

  // Wait for the sort (pushing junk at the input meanwhile), then drain and check.
  task automatic finish_batch(input int v[DEPTH], input bit d, input int bp_beat);
    int exp_s[DEPTH];
    int sw;
    int cyc;
    int n;
    logic [3:0] held;
    model(v, d, exp_s, sw, cyc);
    in_valid = 1'b1;
    in_data  = 4'($urandom_range(0, 15));
    check("busy_sort", busy, 1);
    check("in_ready_sort", in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      in_data = 4'($urandom_range(0, 15));
      check("in_ready_busy", in_ready, 0);
      tick();
      n++;
    end
    check("latency", n, cyc + 1);
    check("swap_count", swap_count, sw);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == bp_beat) begin
        out_ready = 1'b0;
        held = out_data;
        repeat (3) begin
          tick();
          check("bp_valid", out_valid, 1);
          check("bp_data", out_data, held);
        end
        out_ready = 1'b1;
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_s[k]);
      check("out_last", out_last, (k == DEPTH - 1) ? 1 : 0);
      check("in_ready_drain", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("out_valid_done", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("swap_count_hold", swap_count, sw);
  endtask

  task automatic run_batch(input int v[DEPTH], input bit d, input int bp_beat);
    load_batch(v, d);
    finish_batch(v, d, bp_beat);
  endtask

  initial begin
    int v[DEPTH];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    desc      = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready_gated", in_ready, 0);
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_swap_count", swap_count, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Unsorted ascending batch: six SORT cycles, four swaps.
    v = '{5, 3, 10, 1};
    run_batch(v, 1'b0, -1);
    // Already sorted, started immediately after the previous out_last.
    v = '{1, 2, 3, 4};
    run_batch(v, 1'b0, -1);
    // Descending with duplicates, backpressure on the second output beat.
    v = '{10, 3, 10, 5};
    run_batch(v, 1'b1, 1);

    // Reset during the second SORT cycle.
    v = '{5, 3, 10, 1};
    load_batch(v, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready_gated", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_swap_count", swap_count, 0);
    v = '{7, 7, 7, 7};
    run_batch(v, 1'b0, -1);

    // Random batches with random order and random backpressure position.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) v[i] = int'($urandom_range(0, 15));
      run_batch(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH)) - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
